vga_dac_port: RTL and testbench

VGA_DAC_PORT -- requirements
Module: vga_dac_port

---
 rtl/vga_dac_port_if.sv | 26 ++
 rtl/vga_dac_port.sv | 146 ++++++++++++++
 tb/tb_vga_dac_port.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/vga_dac_port_if.sv
// vga_dac_port_if: CPU I/O port and palette RAM byte port bundle for vga_dac_port.
// Ports: io_wr/io_rd/io_sel/io_din -> DAC, io_dout/pel_mask/busy <- DAC,
//        ram_ad/ram_din/ram_we/ram_ce <- DAC, ram_dout -> DAC.
// slave is the DAC side; master is the CPU/RAM side.
interface vga_dac_port_if;
  logic       io_wr;
  logic       io_rd;
  logic [1:0] io_sel;
  logic [7:0] io_din;
  logic [7:0] io_dout;
  logic [7:0] pel_mask;
  logic       busy;
  logic [9:0] ram_ad;
  logic [7:0] ram_din;
  logic       ram_we;
  logic       ram_ce;
  logic [7:0] ram_dout;
  modport slave (
    input  io_wr, io_rd, io_sel, io_din, ram_dout,
    output io_dout, pel_mask, busy, ram_ad, ram_din, ram_we, ram_ce
  );
  modport master (
    output io_wr, io_rd, io_sel, io_din, ram_dout,
    input  io_dout, pel_mask, busy, ram_ad, ram_din, ram_we, ram_ce
  );
endinterface

// File: rtl/vga_dac_port.sv
// vga_dac_port: VGA DAC CPU ports 3C6-3C9 driving a byte-wide palette RAM.
// Ports: clk, reset (sync, active high), bus (vga_dac_port_if.slave):
//   io_wr/io_rd/io_sel/io_din/io_dout CPU side, pel_mask, busy,
//   ram_ad/ram_din/ram_we/ram_ce/ram_dout palette RAM side.
// Option: define VGA_DAC_8BIT_EN for an 8-bit DAC; default is a 6-bit DAC.
module vga_dac_port (
  input logic           clk,
  input logic           reset,
  vga_dac_port_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, WR_R, WR_G, WR_B} seq_t;
  typedef enum logic [1:0] {P_IDLE, RD_ISSUE, RD_WAIT} pf_t;
  localparam logic [1:0] C_R = 2'd2;
  localparam logic [1:0] C_G = 2'd1;
  localparam logic [1:0] C_B = 2'd0;
  seq_t       seq;
  pf_t        pf;
  logic       pf_pend;
  logic [7:0] widx, ridx;
  logic [1:0] wcomp, rcomp;
  logic [7:0] r_hold, g_hold, b_hold, rd_data;
  logic [1:0] dac_state;
  logic       busy_i, wr_go, rd_go;
  function automatic logic [7:0] to_ram(input logic [7:0] d);
`ifdef VGA_DAC_8BIT_EN
    return d;
`else
    return {d[5:0], d[5:4]};
`endif
  endfunction
  function automatic logic [7:0] from_ram(input logic [7:0] d);
`ifdef VGA_DAC_8BIT_EN
    return d;
`else
    return {2'b00, d[7:2]};
`endif
  endfunction
  function automatic logic [1:0] next_comp(input logic [1:0] c);
    return c == C_B ? C_R : c - 2'd1;
  endfunction
  assign busy_i = seq != S_IDLE || pf != P_IDLE || pf_pend;
  assign bus.busy = busy_i;
  // Strobes landing while busy are dropped; a write beats a same-cycle read.
  assign wr_go = bus.io_wr && !busy_i;
  assign rd_go = bus.io_rd && !bus.io_wr && !busy_i;
  always_ff @(posedge clk) begin
    if (reset) begin
      seq          <= S_IDLE;
      pf           <= P_IDLE;
      pf_pend      <= 1'b0;
      widx         <= 8'h00;
      ridx         <= 8'h00;
      wcomp        <= C_R;
      rcomp        <= C_R;
      r_hold       <= 8'h00;
      g_hold       <= 8'h00;
      b_hold       <= 8'h00;
      rd_data      <= 8'h00;
      dac_state    <= 2'b00;
      bus.pel_mask <= 8'hFF;
      bus.io_dout  <= 8'h00;
      bus.ram_ad   <= 10'h000;
      bus.ram_din  <= 8'h00;
      bus.ram_we   <= 1'b0;
      bus.ram_ce   <= 1'b0;
    end else begin
      // RAM port outputs are set on entry to each state so they line up with it.
      case (seq)
        S_IDLE: if (wr_go && bus.io_sel == 2'd3 && wcomp == C_B) begin
          seq         <= WR_R;
          b_hold      <= bus.io_din;
          bus.ram_ad  <= {widx, C_R};
          bus.ram_din <= to_ram(r_hold);
          bus.ram_we  <= 1'b1;
          bus.ram_ce  <= 1'b1;
        end
        WR_R: begin
          seq         <= WR_G;
          bus.ram_ad  <= {widx, C_G};
          bus.ram_din <= to_ram(g_hold);
        end
        WR_G: begin
          seq         <= WR_B;
          bus.ram_ad  <= {widx, C_B};
          bus.ram_din <= to_ram(b_hold);
        end
        WR_B: begin
          seq        <= S_IDLE;
          widx       <= widx + 8'd1;
          bus.ram_we <= 1'b0;
          bus.ram_ce <= 1'b0;
        end
      endcase
      // Prefetch only takes the RAM port once the write sequencer is idle.
      case (pf)
        P_IDLE: if (pf_pend && seq == S_IDLE) begin
          pf         <= RD_ISSUE;
          pf_pend    <= 1'b0;
          bus.ram_ad <= {ridx, rcomp};
          bus.ram_we <= 1'b0;
          bus.ram_ce <= 1'b1;
        end
        RD_ISSUE: begin
          pf         <= RD_WAIT;
          bus.ram_ce <= 1'b0;
        end
        RD_WAIT: begin
          pf      <= P_IDLE;
          rd_data <= bus.ram_dout;
        end
        default: pf <= P_IDLE;
      endcase
      if (wr_go) begin
        case (bus.io_sel)
          2'd0: bus.pel_mask <= bus.io_din;
          2'd1: begin
            ridx      <= bus.io_din;
            rcomp     <= C_R;
            dac_state <= 2'b11;
            pf_pend   <= 1'b1;
          end
          2'd2: begin
            widx      <= bus.io_din;
            wcomp     <= C_R;
            dac_state <= 2'b00;
          end
          2'd3: begin
            if (wcomp == C_R) r_hold <= bus.io_din;
            if (wcomp == C_G) g_hold <= bus.io_din;
            wcomp <= next_comp(wcomp);
          end
        endcase
      end
      if (rd_go) begin
        bus.io_dout <= bus.io_sel == 2'd0 ? bus.pel_mask :
                       bus.io_sel == 2'd1 ? {6'b0, dac_state} :
                       bus.io_sel == 2'd2 ? widx : from_ram(rd_data);
        if (bus.io_sel == 2'd3) begin
          rcomp   <= next_comp(rcomp);
          pf_pend <= 1'b1;
          if (rcomp == C_B) ridx <= ridx + 8'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_vga_dac_port.sv
// tb_vga_dac_port: scoreboard bench for vga_dac_port with a behavioural palette RAM.
module tb_vga_dac_port;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  vga_dac_port_if vif ();
  vga_dac_port dut (.clk(clk), .reset(reset), .bus(vif));
  logic [7:0] mem [1024];
  always @(posedge clk)
    if (vif.ram_ce) begin
      if (vif.ram_we) mem[vif.ram_ad] <= vif.ram_din;
      else vif.ram_dout <= mem[vif.ram_ad];
    end
  int checks = 0;
  int failures = 0;
  int wr_seen = 0;
  logic [17:0] wq [$];
  logic [7:0]  rq [$];
  function automatic logic [7:0] to_ram(input logic [7:0] d);
`ifdef VGA_DAC_8BIT_EN
    return d;
`else
    return {d[5:0], d[5:4]};
`endif
  endfunction
  function automatic logic [17:0] wexp(input logic [9:0] ad, input logic [7:0] d);
    return {ad, to_ram(d)};
  endfunction
  // Advance to the next falling edge, retiring RAM writes and read data against the queues.
  task automatic step(input int n);
    logic r;
    logic [17:0] e;
    logic [7:0] d;
    for (int i = 0; i < n; i++) begin
      r = vif.io_rd && !vif.io_wr;
      @(negedge clk);
      if (vif.ram_we === 1'b1) begin
        wr_seen++;
        checks++;
        if (wq.size() == 0) begin
          failures++;
          $display("FAIL ram_write unexpected: got ad=%h din=%h", vif.ram_ad, vif.ram_din);
        end else begin
          e = wq.pop_front();
          if ({vif.ram_ad, vif.ram_din} !== e) begin
            failures++;
            $display("FAIL ram_write: got ad=%h din=%h want ad=%h din=%h", vif.ram_ad, vif.ram_din, e[17:8], e[7:0]);
          end
        end
      end
      if (r) begin
        checks++;
        if (rq.size() == 0) begin
          failures++;
          $display("FAIL io_dout: read with no expectation, got %h", vif.io_dout);
        end else begin
          d = rq.pop_front();
          if (vif.io_dout !== d) begin
            failures++;
            $display("FAIL io_dout: got %h want %h", vif.io_dout, d);
          end
        end
      end
    end
  endtask
  task automatic cpu_wr(input logic [1:0] sel, input logic [7:0] d);
    vif.io_wr = 1'b1; vif.io_sel = sel; vif.io_din = d;
    step(1);
    vif.io_wr = 1'b0;
    step(7);
  endtask
  task automatic cpu_rd(input logic [1:0] sel, input logic [7:0] exp_d);
    rq.push_back(exp_d);
    vif.io_rd = 1'b1; vif.io_sel = sel;
    step(1);
    vif.io_rd = 1'b0;
    step(7);
  endtask
  task automatic test_reset();
    reset = 1'b1;
    step(3);
    checks += 5;
    if (vif.pel_mask !== 8'hFF) begin failures++; $display("FAIL reset pel_mask: got %h want ff", vif.pel_mask); end
    if (vif.busy !== 1'b0) begin failures++; $display("FAIL reset busy: got %b want 0", vif.busy); end
    if (vif.ram_we !== 1'b0) begin failures++; $display("FAIL reset ram_we: got %b want 0", vif.ram_we); end
    if (vif.ram_ce !== 1'b0) begin failures++; $display("FAIL reset ram_ce: got %b want 0", vif.ram_ce); end
    if (vif.io_dout !== 8'h00) begin failures++; $display("FAIL reset io_dout: got %h want 00", vif.io_dout); end
    reset = 1'b0;
    step(2);
    cpu_rd(2'd2, 8'h00);
    cpu_rd(2'd1, 8'h00);
    cpu_rd(2'd0, 8'hFF);
  endtask
  task automatic test_write_seq();
    int base;
    cpu_wr(2'd2, 8'h10);
    cpu_wr(2'd3, 8'h3F);
    cpu_wr(2'd3, 8'h20);
    wq.push_back(wexp(10'h042, 8'h3F));
    wq.push_back(wexp(10'h041, 8'h20));
    wq.push_back(wexp(10'h040, 8'h05));
    base = wr_seen;
    vif.io_wr = 1'b1; vif.io_sel = 2'd3; vif.io_din = 8'h05;
    step(1);
    vif.io_wr = 1'b0;
    step(2);
    checks++;
    if (wr_seen !== base + 3) begin failures++; $display("FAIL write_consecutive: got %0d writes want 3", wr_seen - base); end
    step(1);
    checks++;
    if (vif.busy !== 1'b0) begin failures++; $display("FAIL write_done busy: got %b want 0", vif.busy); end
    step(4);
    cpu_rd(2'd2, 8'h11);
    cpu_wr(2'd3, 8'h2A);
    cpu_wr(2'd3, 8'h15);
    wq.push_back(wexp(10'h046, 8'h2A));
    wq.push_back(wexp(10'h045, 8'h15));
    wq.push_back(wexp(10'h044, 8'h0B));
    cpu_wr(2'd3, 8'h0B);
  endtask
  task automatic test_read();
    cpu_wr(2'd1, 8'h10);
    cpu_rd(2'd3, 8'h3F);
    cpu_rd(2'd3, 8'h20);
    cpu_rd(2'd3, 8'h05);
    cpu_rd(2'd3, 8'h2A);
    cpu_rd(2'd1, 8'h03);
  endtask
  task automatic test_wrap();
    cpu_wr(2'd2, 8'hFF);
    cpu_wr(2'd3, 8'h01);
    cpu_wr(2'd3, 8'h02);
    wq.push_back(wexp(10'h3FE, 8'h01));
    wq.push_back(wexp(10'h3FD, 8'h02));
    wq.push_back(wexp(10'h3FC, 8'h03));
    cpu_wr(2'd3, 8'h03);
    cpu_rd(2'd2, 8'h00);
    cpu_rd(2'd1, 8'h00);
  endtask
  task automatic test_pel_mask();
    cpu_wr(2'd0, 8'h5A);
    checks++;
    if (vif.pel_mask !== 8'h5A) begin failures++; $display("FAIL pel_mask: got %h want 5a", vif.pel_mask); end
    cpu_rd(2'd0, 8'h5A);
    cpu_wr(2'd0, 8'hFF);
  endtask
  task automatic test_busy_ignore();
    cpu_wr(2'd2, 8'h20);
    cpu_wr(2'd3, 8'h11);
    cpu_wr(2'd3, 8'h22);
    wq.push_back(wexp(10'h082, 8'h11));
    wq.push_back(wexp(10'h081, 8'h22));
    wq.push_back(wexp(10'h080, 8'h33));
    vif.io_wr = 1'b1; vif.io_sel = 2'd3; vif.io_din = 8'h33;
    step(1);
    vif.io_wr = 1'b0;
    step(1);
    checks++;
    if (vif.busy !== 1'b1) begin failures++; $display("FAIL busy_during_seq: got %b want 1", vif.busy); end
    vif.io_wr = 1'b1; vif.io_din = 8'h44;
    step(1);
    vif.io_wr = 1'b0;
    step(6);
    cpu_wr(2'd3, 8'h01);
    cpu_wr(2'd3, 8'h02);
    wq.push_back(wexp(10'h086, 8'h01));
    wq.push_back(wexp(10'h085, 8'h02));
    wq.push_back(wexp(10'h084, 8'h03));
    cpu_wr(2'd3, 8'h03);
    cpu_rd(2'd0, 8'hFF);
    vif.io_wr = 1'b1; vif.io_rd = 1'b1; vif.io_sel = 2'd2; vif.io_din = 8'h50;
    step(1);
    vif.io_wr = 1'b0; vif.io_rd = 1'b0;
    checks++;
    if (vif.io_dout !== 8'hFF) begin failures++; $display("FAIL wr_rd_same_cycle io_dout: got %h want ff", vif.io_dout); end
    step(7);
    cpu_rd(2'd2, 8'h50);
  endtask
  task automatic test_reset_mid_seq();
    cpu_wr(2'd2, 8'h30);
    cpu_wr(2'd3, 8'h0A);
    cpu_wr(2'd3, 8'h0B);
    wq.push_back(wexp(10'h0C2, 8'h0A));
    vif.io_wr = 1'b1; vif.io_sel = 2'd3; vif.io_din = 8'h0C;
    step(1);
    vif.io_wr = 1'b0;
    // Reset lands on the edge that moves the sequencer into WR_G.
    reset = 1'b1;
    step(1);
    checks += 4;
    if (vif.ram_we !== 1'b0) begin failures++; $display("FAIL reset_mid ram_we: got %b want 0", vif.ram_we); end
    if (vif.ram_ce !== 1'b0) begin failures++; $display("FAIL reset_mid ram_ce: got %b want 0", vif.ram_ce); end
    if (vif.busy !== 1'b0) begin failures++; $display("FAIL reset_mid busy: got %b want 0", vif.busy); end
    if (mem[10'h0C2] !== to_ram(8'h0A)) begin failures++; $display("FAIL reset_mid ram[0c2]: got %h want %h", mem[10'h0C2], to_ram(8'h0A)); end
    reset = 1'b0;
    step(3);
    cpu_rd(2'd2, 8'h00);
    cpu_wr(2'd1, 8'h30);
    cpu_rd(2'd3, 8'h0A);
  endtask
  initial begin
    vif.io_wr = 1'b0; vif.io_rd = 1'b0; vif.io_sel = 2'd0; vif.io_din = 8'h00;
    @(negedge clk);
    test_reset();
    test_write_seq();
    test_read();
    test_wrap();
    test_pel_mask();
    test_busy_ignore();
    test_reset_mid_seq();
    checks += 2;
    if (wq.size() != 0) begin failures++; $display("FAIL ram_write missing: %0d pending", wq.size()); end
    if (rq.size() != 0) begin failures++; $display("FAIL io_dout missing: %0d pending", rq.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
